// File: rtl/combi_vec_driver.sv
// Vector driver for combi_logic: replays a preloaded operand table, holds each
// vector HOLD cycles, captures the result into a readback buffer and keeps a running sum.
module combi_vec_driver #(
  parameter int ADDR_W = 3,
  parameter int HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_a,
  input  logic [3:0]        wr_b,
  input  logic [7:0]        wr_c,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              start,
  output logic [3:0]        a_out,
  output logic [3:0]        b_out,
  output logic [7:0]        c_out,
  input  logic [7:0]        result_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sum
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       tbl_q  [DEPTH];
  logic [7:0]        rbuf_q [DEPTH];
  logic [3:0]        a_q, b_q;
  logic [7:0]        c_q, rd_q, sum_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        hold_q;
  logic [ADDR_W:0]   n_q;

  logic              accept, zero_run, cap, last, wr_ok;
  logic [ADDR_W:0]   n_sel;
  logic [15:0]       vec0, vec_next;

  assign wr_ok = wr_en && (state_q == IDLE);
  assign n_sel = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  // A write to entry 0 in the start cycle must be visible to the first vector.
  assign vec0     = (wr_en && (wr_addr == '0)) ? {wr_a, wr_b, wr_c} : tbl_q[0];
  assign vec_next = tbl_q[idx_q + 1'b1];

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    zero_run = 1'b0;
    cap      = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vec == '0) begin
            zero_run = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          cap = 1'b1;
          if (({1'b0, idx_q} + 1'b1) >= n_q) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i]  <= '0;
        rbuf_q[i] <= '0;
      end
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      rd_q   <= '0;
      sum_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      hold_q <= '0;
      n_q    <= '0;
    end else begin
      rd_q <= rbuf_q[rd_addr];
      if (wr_ok) tbl_q[wr_addr] <= {wr_a, wr_b, wr_c};

      if (zero_run) begin
        done_q <= 1'b1;
        sum_q  <= '0;
      end

      if (accept) begin
        n_q               <= n_sel;
        idx_q             <= '0;
        hold_q            <= '0;
        {a_q, b_q, c_q}   <= vec0;
        sum_q             <= '0;
        done_q            <= 1'b0;
        busy_q            <= 1'b1;
      end

      if (state_q == DRIVE) begin
        if (cap) begin
          rbuf_q[idx_q] <= result_in;
          sum_q         <= sum_q + result_in;
          hold_q        <= '0;
          if (last) begin
            {a_q, b_q, c_q} <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
          end else begin
            idx_q           <= idx_q + 1'b1;
            {a_q, b_q, c_q} <= vec_next;
          end
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign c_out   = c_q;
  assign rd_data = rd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;

endmodule
